lfo_rate_latch_unit: RTL and testbench
======================================

Name: lfo_rate_latch_unit

Overview:
- Synchronous, single-clock rework of the chorus/LFO helper logic: a bank of set/clear latches plus an 8-bit to 15-bit exponential rate map driving a period timer.
- The latch bank captures active-low pulsed data from the input mux and is cleared by a frame strobe.
- The rate map converts the 8-bit RATE register into a 15-bit period.
- The timer emits one tick per period, which advances the LFO.

Parameters:
- LATCH_W, 16, number of latch bits in the bank (1..32).

Ports:
- PIN_CLK_IN  in  1  sole clock; all state updates on rising edge.
- PIN_nRESET  in  1  reset, synchronous, active-low.
- nset  in  LATCH_W  per-bit active-low set request.
- nclr  in  1  active-low clear for the whole bank.
- latch_q  out  LATCH_W  latch bank state.
- rate  in  8  rate register value (0 = slowest, 255 = fastest).
- rate_tr  out  15  mapped period value.
- cnt_en  in  1  timer advance enable.
- count  out  15  current timer value.
- rate_tick  out  1  one-cycle period tick.

Behaviour:
- Reset, sampled synchronously on PIN_CLK_IN while PIN_nRESET = 0:
  - latch_q = 0, count = 0, rate_tick = 0.
  - rate_tr is combinational, so it is unaffected by reset (see Optional Feature for the registered variant).
  - Reset has priority over all other inputs.
- Latch bank, evaluated per bit i on each clock, 1-cycle latency:
  - nset[i] = 0: latch_q[i] <= 1. Set wins when nclr is also 0, matching NAND-latch Q behaviour.
  - else nclr = 0: latch_q[i] <= 0.
  - else: hold.
  - All-ones nset is the idle code.
- Rate map, combinational:
  - n = 255 - rate.
  - e = n[7:4], m = n[3:0].
  - t = {1'b1, m} zero-extended to 20 bits, shifted left by e.
  - rate_tr = t[19:5].
  - Monotonic: rate_tr decreases as rate increases.
  - Range 0 (rate = 255) to 0x7C00 = 31744 (rate = 0).
  - No overflow is possible; bit 14 of rate_tr is used.
- Timer, clocked:
  - cnt_en = 0: count holds, rate_tick <= 0.
  - cnt_en = 1 and count >= rate_tr: count <= 0, rate_tick <= 1.
  - cnt_en = 1 otherwise: count <= count + 1, rate_tick <= 0.
  - Tick period = rate_tr + 1 enabled cycles. rate_tr = 0 gives a tick on every enabled cycle.
  - The >= comparison means that when rate drops below the current count, the next enabled cycle wraps immediately; the count never runs to 2^15.
  - count is 15-bit unsigned and is never incremented past rate_tr.
- Reset mid-period restarts the timer at 0 with no tick.
- rate changes take effect on the same cycle's comparison (combinational path).

Optional Feature:
- RATE_MAP_REG_EN defined:
  - rate_tr is registered (reset value 0x7C00, the rate = 0 mapping).
  - Timer comparison uses the registered value, so a rate change reaches rate_tr and the timer one cycle later.
- Not defined: rate_tr is purely combinational as described above.

Test Plan:
- Reset with nset = 0x0000, cnt_en = 1 held -> after the reset edge: latch_q = 0, count = 0, rate_tick = 0.
- nset = 0xFFFE one cycle, then nclr = 0 together with nset = 0xFF7F -> latch_q = 0x0001, then latch_q = 0x0080 (bit 7 set wins, bit 0 cleared). Then idle with nclr = 1 -> holds 0x0080.
- Rate map sweep (combinational):
  - rate = 255 -> 0
  - rate = 0xEF -> 1
  - rate = 0x7F -> 128
  - rate = 0x00 -> 31744
  - full 0..255 sweep is monotonic non-increasing.
- Timer periods with cnt_en = 1:
  - rate = 0xEF -> rate_tick every 2 cycles, count toggles 0/1.
  - rate = 255 -> rate_tick every cycle.
  - cnt_en = 0 for 3 cycles mid-period -> count frozen, no tick.
- rate = 0x7F and count reaches 100, then rate = 0xEF -> next enabled cycle gives count = 0 and rate_tick = 1.
- With RATE_MAP_REG_EN defined: after reset rate_tr = 0x7C00; rate = 0xEF is applied -> rate_tr = 1 one cycle later.

Source files
------------

// File: rtl/lfo_rate_latch_unit.sv
// lfo_rate_latch_unit
//   Set/clear latch bank, 8-bit -> 15-bit exponential rate map and a
//   period timer that emits one tick per mapped period.
//   Optional build macro: RATE_MAP_REG_EN registers the mapped period
//   (reset value 0x7C00), delaying rate changes by one cycle.
module lfo_rate_latch_unit #(
  parameter int LATCH_W = 16
) (
  input  logic               PIN_CLK_IN,
  input  logic               PIN_nRESET,
  input  logic [LATCH_W-1:0] nset,
  input  logic               nclr,
  output logic [LATCH_W-1:0] latch_q,
  input  logic [7:0]         rate,
  output logic [14:0]        rate_tr,
  input  logic               cnt_en,
  output logic [14:0]        count,
  output logic               rate_tick
);

  logic [LATCH_W-1:0] r_latch;
  logic [14:0]        r_count;
  logic               r_tick;
  logic [14:0]        w_rate_map;
  logic [14:0]        w_rate_tr;

  // Exponential map: invert rate, split into 4-bit exponent/mantissa,
  // shift {1,m} by e and keep the upper 15 bits of the 20-bit result.
  function automatic logic [14:0] map_rate(input logic [7:0] r);
    logic [7:0]  n;
    logic [19:0] t;
    n = 8'd255 - r;
    t = {15'd0, 1'b1, n[3:0]} << n[7:4];
    return t[19:5];
  endfunction

  assign w_rate_map = map_rate(rate);

`ifdef RATE_MAP_REG_EN
  logic [14:0] r_rate_tr;

  // Register the mapped period; reset to the slowest (rate = 0) period.
  always_ff @(posedge PIN_CLK_IN) begin
    if (!PIN_nRESET) r_rate_tr <= 15'h7C00;
    else             r_rate_tr <= w_rate_map;
  end

  assign w_rate_tr = r_rate_tr;
`else
  assign w_rate_tr = w_rate_map;
`endif

  // Latch bank: set dominates clear (NAND-latch behaviour), otherwise hold.
  always_ff @(posedge PIN_CLK_IN) begin
    if (!PIN_nRESET) r_latch <= '0;
    else             r_latch <= (r_latch & {LATCH_W{nclr}}) | ~nset;
  end

  // Period timer: wrap and tick once count reaches (or exceeds) the period.
  always_ff @(posedge PIN_CLK_IN) begin
    if (!PIN_nRESET) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (cnt_en) begin
      if (r_count >= w_rate_tr) begin
        r_count <= '0;
        r_tick  <= 1'b1;
      end else begin
        r_count <= r_count + 15'd1;
        r_tick  <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign latch_q   = r_latch;
  assign rate_tr   = w_rate_tr;
  assign count     = r_count;
  assign rate_tick = r_tick;

endmodule

// File: tb/tb_lfo_rate_latch_unit.sv
// Scoreboard bench for lfo_rate_latch_unit: a driver pushes the expected
// post-edge outputs from a behavioural model; a monitor pops and compares.
module tb_lfo_rate_latch_unit;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] nset;
  logic          nclr;
  logic [LW-1:0] latch_q;
  logic [7:0]    rate;
  logic [14:0]   rate_tr;
  logic          cnt_en;
  logic [14:0]   count;
  logic          rate_tick;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [LW-1:0] latch;
    logic [14:0]   cnt;
    logic          tick;
    logic [14:0]   rtr;
  } exp_t;

  exp_t sb[$];

  // Behavioural model state
  logic [LW-1:0] m_latch;
  int            m_count;
  bit            m_tick;
  int            m_rtr;

  lfo_rate_latch_unit #(.LATCH_W(LW)) dut (
    .PIN_CLK_IN(clk),
    .PIN_nRESET(rst_n),
    .nset(nset),
    .nclr(nclr),
    .latch_q(latch_q),
    .rate(rate),
    .rate_tr(rate_tr),
    .cnt_en(cnt_en),
    .count(count),
    .rate_tick(rate_tick)
  );

  always #5 clk = ~clk;

  // Period = (16 + m) * 2^e / 32 with n = 255 - rate, e = n / 16, m = n % 16
  function automatic int ref_map(input int r);
    int n;
    n = 255 - r;
    return ((16 + (n % 16)) * (1 << (n / 16))) / 32;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and push the model's
  // expectation for the outputs after the following rising edge.
  task automatic step(input bit r_n, input logic [LW-1:0] ns, input bit nc,
                      input logic [7:0] rt, input bit en);
    int   thr;
    exp_t e;
    @(negedge clk);
    rst_n = r_n; nset = ns; nclr = nc; rate = rt; cnt_en = en;
`ifdef RATE_MAP_REG_EN
    thr = m_rtr;
`else
    thr = ref_map(rt);
`endif
    if (!r_n) begin
      m_latch = '0;
      m_count = 0;
      m_tick  = 0;
      m_rtr   = 32'h7C00;
    end else begin
      for (int i = 0; i < LW; i++) begin
        if (!ns[i])   m_latch[i] = 1'b1;
        else if (!nc) m_latch[i] = 1'b0;
      end
      if (en) begin
        if (m_count >= thr) begin m_count = 0; m_tick = 1; end
        else begin m_count = m_count + 1; m_tick = 0; end
      end else begin
        m_tick = 0;
      end
      m_rtr = ref_map(rt);
    end
    e.latch = m_latch;
    e.cnt   = m_count[14:0];
    e.tick  = m_tick;
`ifdef RATE_MAP_REG_EN
    e.rtr   = m_rtr[14:0];
`else
    e.rtr   = ref_map(rt);
`endif
    sb.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic step_s(input bit r_n, input logic [LW-1:0] ns, input bit nc,
                        input logic [7:0] rt, input bit en);
    step(r_n, ns, nc, rt, en);
    settle();
  endtask

  // Monitor: every output set after a rising edge is compared with the
  // oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb latch_q", int'(latch_q), int'(e.latch));
        check("sb count", int'(count), int'(e.cnt));
        check("sb rate_tick", int'(rate_tick), int'(e.tick));
        check("sb rate_tr", int'(rate_tr), int'(e.rtr));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    logic [7:0] rt;
    rst_n = 1'b0; nset = '1; nclr = 1'b1; rate = 8'd0; cnt_en = 1'b0;
    m_latch = '0; m_count = 0; m_tick = 0; m_rtr = 32'h7C00;

    // Reset with set requests and enable active
    step_s(0, 16'h0000, 1, 8'h00, 1);
    step_s(0, 16'h0000, 1, 8'h00, 1);
    check("reset latch_q", int'(latch_q), 0);
    check("reset count", int'(count), 0);
    check("reset rate_tick", int'(rate_tick), 0);
`ifdef RATE_MAP_REG_EN
    check("reset rate_tr", int'(rate_tr), 32'h7C00);
    step(1, 16'hFFFF, 1, 8'hEF, 0);
    #1;
    check("reg rate_tr before edge", int'(rate_tr), 32'h7C00);
    settle();
    check("reg rate_tr after edge", int'(rate_tr), 1);
`endif

    // Latch set / set-wins-over-clear / hold
    step_s(1, 16'hFFFE, 1, 8'h00, 0);
    check("latch set bit0", int'(latch_q), 32'h0001);
    step_s(1, 16'hFF7F, 0, 8'h00, 0);
    check("latch set7 clear0", int'(latch_q), 32'h0080);
    step_s(1, 16'hFFFF, 1, 8'h00, 0);
    check("latch hold", int'(latch_q), 32'h0080);

    // Rate map spot values
    step_s(1, 16'hFFFF, 1, 8'hFF, 0);
    check("map 0xFF", int'(rate_tr), 0);
    step_s(1, 16'hFFFF, 1, 8'hEF, 0);
    check("map 0xEF", int'(rate_tr), 1);
    step_s(1, 16'hFFFF, 1, 8'h7F, 0);
    check("map 0x7F", int'(rate_tr), 128);
    step_s(1, 16'hFFFF, 1, 8'h00, 0);
    check("map 0x00", int'(rate_tr), 31744);

    // Full sweep: exact value and non-increasing against previous rate
    for (int r = 0; r < 256; r++) begin
      step_s(1, 16'hFFFF, 1, r[7:0], 0);
      check("sweep value", int'(rate_tr), ref_map(r));
      if (r > 0 && int'(rate_tr) > ref_map(r - 1))
        check("sweep monotonic", int'(rate_tr), ref_map(r - 1));
    end

    // Timer, rate = 0xEF: tick every 2 enabled cycles
    step_s(0, 16'hFFFF, 1, 8'hEF, 0);
    step_s(1, 16'hFFFF, 1, 8'hEF, 0);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step_s(1, 16'hFFFF, 1, 8'hEF, 1);
      ticks += int'(rate_tick);
      check("period2 count", int'(count), (i % 2 == 0) ? 1 : 0);
    end
    check("period2 ticks", ticks, 4);

    // Timer, rate = 0xFF: tick every enabled cycle
    step_s(1, 16'hFFFF, 1, 8'hFF, 0);
    ticks = 0;
    for (int i = 0; i < 5; i++) begin
      step_s(1, 16'hFFFF, 1, 8'hFF, 1);
      ticks += int'(rate_tick);
    end
    check("period1 ticks", ticks, 5);

    // rate = 0x7F: freeze mid-period, then run up to 100 and shrink period
    step_s(0, 16'hFFFF, 1, 8'h7F, 0);
    step_s(1, 16'hFFFF, 1, 8'h7F, 0);
    for (int i = 0; i < 5; i++) step_s(1, 16'hFFFF, 1, 8'h7F, 1);
    ticks = 0;
    for (int i = 0; i < 3; i++) begin
      step_s(1, 16'hFFFF, 1, 8'h7F, 0);
      ticks += int'(rate_tick);
    end
    check("freeze count", int'(count), 5);
    check("freeze ticks", ticks, 0);
    for (int i = 0; i < 95; i++) step_s(1, 16'hFFFF, 1, 8'h7F, 1);
    check("count reached 100", int'(count), 100);
    step_s(1, 16'hFFFF, 1, 8'hEF, 1);
`ifdef RATE_MAP_REG_EN
    check("shrink lag count", int'(count), 101);
    check("shrink lag tick", int'(rate_tick), 0);
    step_s(1, 16'hFFFF, 1, 8'hEF, 1);
`endif
    check("shrink wrap count", int'(count), 0);
    check("shrink wrap tick", int'(rate_tick), 1);

    // Randomised traffic against the model
    rt = 8'hF0;
    for (int i = 0; i < 1500; i++) begin
      logic [LW-1:0] ns;
      if ($urandom_range(0, 31) == 0)
        rt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(200, 255));
      ns = ($urandom_range(0, 3) == 0) ? LW'($urandom) : '1;
      step(($urandom_range(0, 63) != 0), ns, ($urandom_range(0, 7) != 0), rt,
           ($urandom_range(0, 7) != 0));
    end

    settle();
    settle();
    check("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
